// File: rtl/uart_tx_serial.sv
// uart_tx_serial: 8N1 serial transmitter with a small character FIFO.
// Characters arrive over a valid/ready handshake, queue in a circular buffer,
// and are shifted out LSB first: one start bit, eight data bits, one stop bit.
// Every bit lasts exactly CLK_DIV clk cycles. Back-to-back frames have no idle gap.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   i_data   character to transmit
//   i_valid  i_data valid this cycle
//   o_ready  FIFO can accept; push happens when i_valid && o_ready
//   o_tx     serial line, idle high, registered
//   o_busy   frame on the line or FIFO non-empty
//   o_level  FIFO occupancy, 0..FIFO_DEPTH
module uart_tx_serial #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(CLK_DIV);

    localparam logic [LvlW-1:0]  LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // FIFO storage and bookkeeping
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic            push, pop;
    logic [7:0]      head;

    // Transmit FSM
    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    // Ready comes only from registered occupancy (plus reset), never from i_valid.
    assign o_ready = (level_q != LvlFull) && !rst;
    assign push    = i_valid && o_ready;
    assign head    = mem[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    bit_d   = 3'd0;
                    baud_d  = BaudMax;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_q == '0) begin
                    baud_d  = BaudMax;
                    state_d = StData;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            StData: begin
                if (baud_q == '0) begin
                    baud_d = BaudMax;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            StStop: begin
                if (baud_q == '0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (level_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        bit_d   = 3'd0;
                        baud_d  = BaudMax;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level follows the state being entered so o_tx can be registered.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            level_q  <= level_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    assign o_tx    = tx_q;
    assign o_level = level_q;
    assign o_busy  = (state_q != StIdle) || (level_q != '0);

endmodule

// File: tb/tb_uart_tx_serial.sv
// Bench for uart_tx_serial: two instances (CLK_DIV=4 and CLK_DIV=2, depth 4)
// checked every cycle against a frame-timeline model. Each accepted byte becomes
// a frame whose start edge is max(push edge + 1, end of previous frame); line
// level, occupancy, busy and ready all follow from that list arithmetically.
module tb_uart_tx_serial;

    localparam int Depth = 4;
    localparam int DivA  = 4;
    localparam int DivB  = 2;
    localparam int MaxFr = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dat  [2];
    logic       vld  [2];
    logic       rdy  [2];
    logic       tx   [2];
    logic       busy [2];
    logic [2:0] lvl  [2];

    uart_tx_serial #(.CLK_DIV(DivA), .FIFO_DEPTH(Depth)) u_dut_a (
        .clk(clk), .rst(rst), .i_data(dat[0]), .i_valid(vld[0]),
        .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_level(lvl[0])
    );

    uart_tx_serial #(.CLK_DIV(DivB), .FIFO_DEPTH(Depth)) u_dut_b (
        .clk(clk), .rst(rst), .i_data(dat[1]), .i_valid(vld[1]),
        .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_level(lvl[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Frame list per instance: push edge, start edge, byte.
    int         fr_e [2][MaxFr];
    int         fr_s [2][MaxFr];
    logic [7:0] fr_d [2][MaxFr];
    int         nfr      [2];
    int         lo       [2];
    int         last_end [2];

    logic       drv_v [2];
    logic [7:0] drv_d [2];
    bit         acc   [2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? DivA : DivB;
    endfunction

    function automatic int exp_level(input int u);
        int n = 0;
        for (int k = lo[u]; k < nfr[u]; k++)
            if (fr_e[u][k] <= cyc && fr_s[u][k] > cyc) n++;
        return n;
    endfunction

    function automatic int exp_active(input int u);
        for (int k = lo[u]; k < nfr[u]; k++)
            if (fr_s[u][k] <= cyc && cyc < fr_s[u][k] + 10 * div_of(u)) return 1;
        return 0;
    endfunction

    function automatic int exp_tx(input int u);
        for (int k = lo[u]; k < nfr[u]; k++) begin
            if (fr_s[u][k] <= cyc && cyc < fr_s[u][k] + 10 * div_of(u)) begin
                int b;
                b = (cyc - fr_s[u][k]) / div_of(u);
                if (b == 0) return 0;
                if (b == 9) return 1;
                return int'(fr_d[u][k][b-1]);
            end
        end
        return 1;
    endfunction

    // One clock: drive inputs, advance the model on the edge, check #1 later.
    task automatic step(input bit r);
        bit take [2];
        rst = r;
        for (int u = 0; u < 2; u++) begin
            vld[u]  = drv_v[u];
            dat[u]  = drv_d[u];
            take[u] = drv_v[u] && !r && (exp_level(u) != Depth);
        end
        @(posedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (r) begin
                lo[u]       = nfr[u];
                last_end[u] = 0;
            end else if (take[u] && nfr[u] < MaxFr) begin
                int s;
                s = (cyc + 1 > last_end[u]) ? cyc + 1 : last_end[u];
                fr_e[u][nfr[u]] = cyc;
                fr_s[u][nfr[u]] = s;
                fr_d[u][nfr[u]] = drv_d[u];
                nfr[u]++;
                last_end[u] = s + 10 * div_of(u);
            end
            acc[u] = take[u];
            while (lo[u] < nfr[u] && fr_s[u][lo[u]] + 10 * div_of(u) <= cyc) lo[u]++;
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            int el;
            el = exp_level(u);
            check($sformatf("tx%0d", u), int'(tx[u]), exp_tx(u));
            check($sformatf("level%0d", u), int'(lvl[u]), el);
            check($sformatf("busy%0d", u), int'(busy[u]),
                  ((el != 0) || (exp_active(u) != 0)) ? 1 : 0);
            check($sformatf("ready%0d", u), int'(rdy[u]), (!r && el != Depth) ? 1 : 0);
        end
    endtask

    task automatic idle(input int n);
        drv_v[0] = 1'b0;
        drv_v[1] = 1'b0;
        repeat (n) step(1'b0);
    endtask

    logic [7:0] hello [6];
    int         idx   [2];
    int         peak  [2];

    initial begin
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};
        for (int u = 0; u < 2; u++) begin
            nfr[u] = 0; lo[u] = 0; last_end[u] = 0;
            drv_v[u] = 1'b0; drv_d[u] = 8'h00; idx[u] = 0; peak[u] = 0;
        end

        // Reset, then idle state.
        repeat (3) step(1'b1);
        idle(3);

        // Single character "H".
        drv_v = '{1'b1, 1'b1};
        drv_d = '{8'h48, 8'h48};
        step(1'b0);
        idle(45);

        // "Hello\n" with valid held until each byte is taken.
        for (int n = 0; n < 300; n++) begin
            for (int u = 0; u < 2; u++) begin
                drv_v[u] = (idx[u] < 6);
                drv_d[u] = (idx[u] < 6) ? hello[idx[u]] : 8'h00;
            end
            step(1'b0);
            for (int u = 0; u < 2; u++) begin
                if (acc[u]) idx[u]++;
                if (int'(lvl[u]) > peak[u]) peak[u] = int'(lvl[u]);
            end
        end
        check("hello_peak0", peak[0], Depth);
        check("hello_peak1", peak[1], Depth);
        idle(20);

        // Saturate the FIFO: valid held, random bytes, pushes only when a slot frees.
        for (int n = 0; n < 200; n++) begin
            for (int u = 0; u < 2; u++) begin
                drv_v[u] = 1'b1;
                drv_d[u] = 8'($urandom);
            end
            step(1'b0);
        end
        idle(250);

        // Extreme bit patterns.
        drv_v = '{1'b1, 1'b1};
        drv_d = '{8'hFF, 8'hFF};
        step(1'b0);
        drv_d = '{8'h00, 8'h00};
        step(1'b0);
        idle(100);

        // Reset in the middle of a frame with queued data and a push in the reset cycle.
        drv_v = '{1'b1, 1'b1};
        drv_d = '{8'hA5, 8'h3C};
        repeat (3) step(1'b0);
        idle(9);
        drv_v = '{1'b1, 1'b1};
        repeat (3) step(1'b1);
        idle(5);

        // Random traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            for (int u = 0; u < 2; u++) begin
                drv_v[u] = ($urandom_range(0, 2) == 0);
                drv_d[u] = 8'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                repeat (3) step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        idle(300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
